// File: rtl/alu_pkt_ctrl.sv
// Packet sequencer between the UART RX/TX byte streams and a 32-bit ADD/XOR reduction.
// Optional mid-packet idle timeout enabled by defining ALU_PKT_CTRL_TIMEOUT_EN.
module alu_pkt_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [15:0] MAX_LEN        = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RSVD    = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_LEN_HI  = 4'd3;
  localparam logic [3:0] S_ECHO    = 4'd4;
  localparam logic [3:0] S_FLUSH   = 4'd5;
  localparam logic [3:0] S_OPERAND = 4'd6;
  localparam logic [3:0] S_RESULT  = 4'd7;
  localparam logic [3:0] S_DRAIN   = 4'd8;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_XOR  = 8'hA1;

  logic [3:0]  state;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] remain;
  logic [31:0] acc;
  logic [23:0] asm_word;
  logic [1:0]  byte_idx;
  logic [2:0]  res_cnt;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        err_q;

  logic        rx_ready;
  logic        rx_fire;
  logic        tx_fire;
  logic        tx_slot;
  logic        tx_load;
  logic [7:0]  tx_load_data;
  logic [15:0] len_full;
  logic [15:0] payload;
  logic [31:0] operand;
  logic [31:0] folded;
  logic        len_bad;
  logic        op_known;
  logic        tmo_hit;

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: rx_ready = 1'b1;
      S_ECHO:  rx_ready = !tx_valid_q || tx_ready_i;
      default: rx_ready = 1'b0;
    endcase
  end

  assign rx_fire  = rx_valid_i && rx_ready;
  assign tx_fire  = tx_valid_q && tx_ready_i;
  // Register is free this cycle if empty or emptying; allows back-to-back loads.
  assign tx_slot  = !tx_valid_q || tx_fire;

  assign len_full = {rx_data_i, len_lo};
  assign payload  = len_full - 16'd4;
  assign len_bad  = (len_full < 16'd4) || ({1'b0, len_full} > {1'b0, MAX_LEN});
  assign op_known = (opcode == OP_ECHO) || (opcode == OP_ADD) || (opcode == OP_XOR);
  assign operand  = {rx_data_i, asm_word};
  assign folded   = (opcode == OP_ADD) ? (acc + operand) : (acc ^ operand);

  always_comb begin
    tx_load      = 1'b0;
    tx_load_data = rx_data_i;
    if (state == S_ECHO && rx_fire) begin
      tx_load = 1'b1;
    end else if (state == S_RESULT && tx_slot && res_cnt != 3'd4) begin
      tx_load = 1'b1;
      case (res_cnt[1:0])
        2'd0:    tx_load_data = acc[7:0];
        2'd1:    tx_load_data = acc[15:8];
        2'd2:    tx_load_data = acc[23:16];
        default: tx_load_data = acc[31:24];
      endcase
    end
  end

`ifdef ALU_PKT_CTRL_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_run;

  assign tmo_run = (state != S_IDLE) && (state != S_RESULT) && (state != S_FLUSH);
  assign tmo_hit = tmo_run && !rx_fire && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !tmo_run || rx_fire || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      opcode     <= '0;
      len_lo     <= '0;
      remain     <= '0;
      acc        <= '0;
      asm_word   <= '0;
      byte_idx   <= '0;
      res_cnt    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;

      if (tx_load) begin
        tx_data_q  <= tx_load_data;
        tx_valid_q <= 1'b1;
      end else if (tx_fire) begin
        tx_valid_q <= 1'b0;
      end

      if (tx_load && state == S_RESULT) begin
        res_cnt <= res_cnt + 3'd1;
      end

      if (tmo_hit) begin
        state <= S_IDLE;
        err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (rx_fire) begin
            opcode <= rx_data_i;
            state  <= S_RSVD;
          end
          S_RSVD: if (rx_fire) state <= S_LEN_LO;
          S_LEN_LO: if (rx_fire) begin
            len_lo <= rx_data_i;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: if (rx_fire) begin
            acc      <= '0;
            byte_idx <= '0;
            res_cnt  <= '0;
            remain   <= payload;
            if (len_bad) begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end else if (!op_known) begin
              err_q <= 1'b1;
              state <= (payload != 16'd0) ? S_DRAIN : S_IDLE;
            end else if (payload == 16'd0) begin
              state <= (opcode == OP_ECHO) ? S_IDLE : S_RESULT;
            end else begin
              state <= (opcode == OP_ECHO) ? S_ECHO : S_OPERAND;
            end
          end
          S_ECHO: if (rx_fire) begin
            remain <= remain - 16'd1;
            if (remain == 16'd1) state <= S_FLUSH;
          end
          S_FLUSH: if (tx_slot) state <= S_IDLE;
          S_OPERAND: if (rx_fire) begin
            asm_word <= {rx_data_i, asm_word[23:8]};
            byte_idx <= byte_idx + 2'd1;
            remain   <= remain - 16'd1;
            if (byte_idx == 2'd3) acc <= folded;
            // A trailing partial word means the payload was not a multiple of 4.
            if (remain == 16'd1) begin
              if (byte_idx != 2'd3) begin
                err_q <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_RESULT;
              end
            end
          end
          S_RESULT: if (tx_fire && res_cnt == 3'd4) state <= S_IDLE;
          S_DRAIN: if (rx_fire) begin
            remain <= remain - 16'd1;
            if (remain == 16'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ready_o = rx_ready;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state != S_IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// Directed bench for alu_pkt_ctrl: echo, ADD32/XOR32, error packets, backpressure, reset abort.
module tb_alu_pkt_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_valid_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       rx_ready_o;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_cnt = 0;
  int bp_viol = 0;
  int bp_stall = 0;
  logic bp_mode = 1'b0;
  logic tx_rdy_lvl = 1'b1;
  logic [7:0] txq[$];
  int tx_t[$];
  int rx_t[$];

  assign tx_ready_i = bp_mode ? ((cyc % 3) == 0) : tx_rdy_lvl;

  alu_pkt_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Inputs only change 1ns after posedge, so negedge values are what the next edge sees.
  always @(negedge clk_i) begin
    if (tx_valid_o && tx_ready_i) begin
      txq.push_back(tx_data_o);
      tx_t.push_back(cyc);
    end
    if (rx_valid_i && rx_ready_o) rx_t.push_back(cyc);
    if (err_o) err_cnt++;
    if (bp_mode && tx_valid_o && !tx_ready_i && rx_ready_o) bp_viol++;
    if (bp_mode && rx_valid_i && !rx_ready_o) bp_stall++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bytes(input int n, input logic [127:0] v);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      rx_valid_i = 1'b1;
      rx_data_i  = v[8*(n-1-i) +: 8];
      while (!rx_ready_o && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) begin
        chk("rx_accept_timeout", 32'(w), 32'd0);
        rx_valid_i = 1'b0;
        return;
      end
      tick();
      rx_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_o && w < 200) begin
      tick();
      w++;
    end
    chk("wait_idle_busy", 32'(busy_o), 32'd0);
    tick();
    tick();
  endtask

  task automatic chk_tx(input string tag, input int n, input logic [31:0] exp);
    chk({tag, "_count"}, 32'(txq.size()), 32'(n));
    for (int i = 0; i < n && i < txq.size(); i++)
      chk({tag, "_byte"}, 32'(txq[i]), 32'(exp[8*i +: 8]));
  endtask

  task automatic clear_logs();
    txq.delete();
    tx_t.delete();
    rx_t.delete();
    err_cnt = 0;
  endtask

  initial begin
    tick(); tick(); tick();
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // ECHO of three bytes with 1-cycle latency
    clear_logs();
    send_bytes(7, 56'hEC_00_07_00_61_62_63);
    wait_idle();
    chk_tx("echo", 3, 32'h00_63_62_61);
    for (int i = 0; i < 3 && i < tx_t.size() && rx_t.size() == 7; i++)
      chk("echo_latency", 32'(tx_t[i] - rx_t[4+i]), 32'd1);
    chk("echo_rx_count", 32'(rx_t.size()), 32'd7);
    chk("echo_err", 32'(err_cnt), 32'd0);

    // ADD32 wraps: 1 + FFFFFFFF = 0
    clear_logs();
    send_bytes(12, 96'hA0_00_0C_00_01_00_00_00_FF_FF_FF_FF);
    wait_idle();
    chk_tx("add_wrap", 4, 32'h00000000);
    chk("add_wrap_err", 32'(err_cnt), 32'd0);

    // XOR32: F000000F ^ 000000FF = F00000F0
    clear_logs();
    send_bytes(12, 96'hA1_00_0C_00_0F_00_00_F0_FF_00_00_00);
    wait_idle();
    chk_tx("xor", 4, 32'hF00000F0);

    // Bad LEN
    clear_logs();
    send_bytes(4, 32'hA0_00_02_00);
    wait_idle();
    chk("badlen_err", 32'(err_cnt), 32'd1);
    chk("badlen_tx", 32'(txq.size()), 32'd0);

    // Unknown opcode drains payload, then echo still works
    clear_logs();
    send_bytes(6, 48'h33_00_06_00_AA_BB);
    wait_idle();
    chk("unk_err", 32'(err_cnt), 32'd1);
    chk("unk_rx_count", 32'(rx_t.size()), 32'd6);
    chk("unk_tx", 32'(txq.size()), 32'd0);
    clear_logs();
    send_bytes(5, 40'hEC_00_05_00_5A);
    wait_idle();
    chk_tx("echo_after_unk", 1, 32'h0000005A);
    chk("echo_after_unk_err", 32'(err_cnt), 32'd0);

    // Non-multiple-of-4 operand payload
    clear_logs();
    send_bytes(6, 48'hA0_00_06_00_01_02);
    wait_idle();
    chk("partial_err", 32'(err_cnt), 32'd1);
    chk("partial_tx", 32'(txq.size()), 32'd0);

    // Zero-payload ADD returns 0; zero-payload ECHO returns nothing
    clear_logs();
    send_bytes(4, 32'hA0_00_04_00);
    wait_idle();
    chk_tx("add_empty", 4, 32'h00000000);
    clear_logs();
    send_bytes(4, 32'hEC_00_04_00);
    wait_idle();
    chk("echo_empty_tx", 32'(txq.size()), 32'd0);
    chk("echo_empty_err", 32'(err_cnt), 32'd0);

    // Echo under 1-of-3 TX backpressure
    clear_logs();
    bp_mode = 1'b1;
    send_bytes(8, 64'hEC_00_08_00_11_22_33_44);
    wait_idle();
    bp_mode = 1'b0;
    chk_tx("bp_echo", 4, 32'h44332211);
    chk("bp_rx_ready_while_full", 32'(bp_viol), 32'd0);
    chk("bp_stalled", 32'(bp_stall > 0), 32'd1);

    // Result byte0 held while TX not ready: 5 + 7 = 0C
    clear_logs();
    tx_rdy_lvl = 1'b0;
    send_bytes(12, 96'hA0_00_0C_00_05_00_00_00_07_00_00_00);
    tick(); tick();
    chk("hold_valid_early", 32'(tx_valid_o), 32'd1);
    chk("hold_data_early", 32'(tx_data_o), 32'h0C);
    for (int i = 0; i < 8; i++) tick();
    chk("hold_valid_late", 32'(tx_valid_o), 32'd1);
    chk("hold_data_late", 32'(tx_data_o), 32'h0C);
    chk("hold_no_tx", 32'(txq.size()), 32'd0);
    tx_rdy_lvl = 1'b1;
    wait_idle();
    chk_tx("hold_result", 4, 32'h0000000C);

    // Reset during OPERAND after 6 payload bytes
    clear_logs();
    send_bytes(10, 80'hA0_00_0C_00_01_02_03_04_05_06);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready_o), 32'd1);
    tick();
    chk("midrst_err", 32'(err_cnt), 32'd0);
    send_bytes(12, 96'hA0_00_0C_00_10_00_00_00_20_00_00_00);
    wait_idle();
    chk_tx("after_rst_add", 4, 32'h00000030);

`ifdef ALU_PKT_CTRL_TIMEOUT_EN
    // Stall after LEN_LO: error after 100 idle cycles
    clear_logs();
    send_bytes(3, 24'hA0_00_0C);
    for (int i = 0; i < 90; i++) tick();
    chk("tmo_still_busy", 32'(busy_o), 32'd1);
    chk("tmo_no_err_yet", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("tmo_err", 32'(err_cnt), 32'd1);
    chk("tmo_idle", 32'(busy_o), 32'd0);
    chk("tmo_tx", 32'(txq.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pkt_ctrl.md
Name: alu_pkt_ctrl

Overview:
Packet sequencer between the UART receiver/transmitter byte streams and the integer ALU datapath. It parses framed command packets arriving one byte at a time. Depending on the opcode, it echoes the payload, or reduces the 32-bit payload operands with ADD or XOR and returns a 4-byte result. It sits inside uart_mod, between the RX byte output (valid/data) and the TX byte input (ready/valid).

Parameters:
TIMEOUT_CYCLES, 1_000_000, idle-byte limit mid-packet, in clk_i cycles; used only with the optional feature.
MAX_LEN, 16'hFFFF, largest accepted total packet length in bytes, header included.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
rx_valid_i  in  1  RX byte available
rx_data_i  in  8  RX byte
rx_ready_o  out  1  controller accepts RX byte this cycle
tx_valid_o  out  1  TX byte valid
tx_data_o  out  8  TX byte
tx_ready_i  in  1  TX accepts byte
busy_o  out  1  packet in progress (state != IDLE)
err_o  out  1  one-cycle pulse on any packet error

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: state=IDLE; tx_valid_o=0, tx_data_o=0, busy_o=0, err_o=0, rx_ready_o=1. Accumulator and byte counter are cleared.
- Reset mid-packet: the packet is aborted. A byte held in the TX register is dropped, and no error pulse is issued.
- RX transfer occurs on rx_valid_i && rx_ready_o. TX transfer occurs on tx_valid_o && tx_ready_i.
- tx_valid_o/tx_data_o are registered and held stable until the TX transfer completes.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]. LEN is the total byte count, including the 4 header bytes. The payload is LEN-4 bytes.
- Opcodes:
  - 0xEC ECHO: payload copied to TX.
  - 0xA0 ADD32: sum of little-endian 32-bit operands, modulo 2^32.
  - 0xA1 XOR32: XOR of operands.
- States:
  - IDLE: accept opcode → RSVD.
  - RSVD: accept byte → LEN_LO.
  - LEN_LO: accept byte → LEN_HI.
  - LEN_HI: accept byte, then decode:
    - LEN<4 or LEN>MAX_LEN → err_o pulse, IDLE.
    - Unknown opcode → err_o pulse; DRAIN if payload>0, else IDLE.
    - Payload==0 on ECHO → IDLE.
    - Payload==0 on ADD/XOR → RESULT with accumulator 0.
    - Otherwise → ECHO or OPERAND.
  - ECHO: rx_ready_o = !tx_valid_o || tx_ready_i. Each accepted byte is loaded into the TX register and tx_valid_o is asserted the next cycle (1-cycle latency). After the last payload byte → FLUSH.
  - FLUSH: wait until the TX register is empty → IDLE.
  - OPERAND: rx_ready_o=1. Bytes shift into a 32-bit LE assembly register; every 4th byte is folded into the accumulator. After the last byte:
    - payload%4 != 0 → err_o pulse, IDLE, no result, partial operand discarded.
    - otherwise → RESULT.
  - RESULT: rx_ready_o=0. Emits accumulator bytes [7:0], [15:8], [23:16], [31:24], in that order. The first byte is valid the cycle after entry; each subsequent byte loads on the same cycle the previous one transfers. After the 4th transfer → IDLE.
  - DRAIN: rx_ready_o=1; discards the remaining payload bytes, then → IDLE.
- rx_ready_o=1 in IDLE/RSVD/LEN_LO/LEN_HI/OPERAND/DRAIN, and 0 in FLUSH/RESULT.
- Accumulator resets to 0 at every LEN_HI acceptance. Arithmetic is 32-bit unsigned and wraps with no carry-out.
- A simultaneous TX transfer and new load of the TX register in the same cycle is legal: no bubble, no loss.

Optional Feature:
Macro: ALU_PKT_CTRL_TIMEOUT_EN.
- Defined: a counter runs in every state except IDLE and RESULT/FLUSH, and clears on each RX transfer. Reaching TIMEOUT_CYCLES gives an err_o pulse, abandons the packet (accumulator discarded, no result) and returns to IDLE. A pending TX byte still completes.
- Undefined: there is no counter, and the controller waits indefinitely for bytes.

Test Plan:
- ECHO EC 00 07 00 61 62 63, tx_ready_i=1 → TX 61 62 63, each byte 1 cycle after its RX acceptance; err_o never pulses; busy_o low after the last TX.
- ADD32 A0 00 0C 00 01 00 00 00 FF FF FF FF → TX 00 00 00 00 (wrap).
- XOR32 A1 00 0C 00 0F 00 00 F0 FF 00 00 00 → TX F0 00 00 F0.
- Bad LEN: A0 00 02 00 → err_o one pulse after byte3, no TX. Unknown opcode 33 00 06 00 AA BB → err_o pulse, 2 bytes drained, no TX; a following ECHO packet works normally.
- Backpressure: ECHO of 4 bytes with tx_ready_i toggled 1-of-3 cycles → rx_ready_o deasserts while the TX register is full; output is 4 bytes in order with no duplicates. ADD32 with tx_ready_i low 10 cycles → tx_data_o holds result byte0.
- Reset mid-OPERAND (after 6 payload bytes) → next cycle IDLE, tx_valid_o=0, busy_o=0; a new ADD32 packet gives the correct sum. With ALU_PKT_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, stalling after LEN_LO → err_o at cycle 100, then IDLE.
